// File: rtl/traffic_phase_sequencer_pkg.sv
// rtl/traffic_phase_sequencer_pkg.sv - shared phase encoding, timebase constant and road-index width helper
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_ALLRED = 2'b00,
        PH_GREEN  = 2'b01,
        PH_YELLOW = 2'b10,
        PH_FLASH  = 2'b11
    } phase_e;

    localparam int unsigned CLK_FREQ_DEFAULT = 100_000_000;
    localparam int unsigned HALF_CYCLES      = CLK_FREQ_DEFAULT / 2;

    function automatic int unsigned road_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned half_cycles(input int unsigned clk_freq);
        return clk_freq / 2;
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_tick_gen.sv
// rtl/traffic_phase_sequencer_tick_gen.sv - half-second pulse and blink toggle from the board clock
module tick_gen
    import traffic_pkg::*;
#(
    parameter int unsigned CLK_FREQ = CLK_FREQ_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    output logic half,
    output logic blink
);

    localparam logic [31:0] HALF_LAST = 32'(half_cycles(CLK_FREQ) - 1);

    logic [31:0] cnt_q;
    logic        blink_q;

    assign half  = (cnt_q == HALF_LAST);
    assign blink = blink_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else if (half) begin
            cnt_q   <= '0;
            blink_q <= ~blink_q;
        end else begin
            cnt_q <= cnt_q + 32'd1;
        end
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - N-road green/yellow/all-red sequencer with demand skip, extension and flash mode
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned N_ROADS        = 4,
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned GREEN_TIME     = 30,
    parameter int unsigned YELLOW_TIME    = 3,
    parameter int unsigned ALLRED_TIME    = 1,
    parameter bit          YELLOW_OVERLAP = 1'b1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [N_ROADS-1:0]               demand,
    input  logic                             flash_req,
    output logic [N_ROADS-1:0]               green,
    output logic [N_ROADS-1:0]               yellow,
    output logic [N_ROADS-1:0]               red,
    output logic [N_ROADS-1:0]               right_turn,
    output logic [road_w(N_ROADS)-1:0]       cur_road,
    output logic [1:0]                       phase
);

    localparam int unsigned RW = road_w(N_ROADS);
    localparam logic [7:0] GREEN_LAST  = 8'(2 * GREEN_TIME - 1);
    localparam logic [7:0] YELLOW_LAST = 8'(2 * YELLOW_TIME - 1);
    localparam logic [7:0] ALLRED_LAST = 8'(2 * ALLRED_TIME - 1);

    phase_e          state_q;
    logic [RW-1:0]   cur_q;
    logic [RW-1:0]   nxt_q;
    logic [7:0]      cnt_q;
    logic            half;
    logic            blink;
    logic [7:0]      limit;
    logic            expire;
    logic            found;
    logic [RW-1:0]   sel;

    // Wrap by compare-and-subtract so non-power-of-2 road counts never alias.
    function automatic logic [RW-1:0] add_mod(input logic [RW-1:0] r, input int unsigned k);
        int unsigned s;
        s = 32'(r) + k;
        if (s >= N_ROADS) s = s - N_ROADS;
        return RW'(s);
    endfunction

    tick_gen #(
        .CLK_FREQ(CLK_FREQ)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .half (half),
        .blink(blink)
    );

    always_comb begin
        case (state_q)
            PH_GREEN:  limit = GREEN_LAST;
            PH_YELLOW: limit = YELLOW_LAST;
            default:   limit = ALLRED_LAST;
        endcase
        expire = half && (cnt_q == limit);
    end

    // Descending scan so the nearest road after cur_q wins.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        for (int unsigned k = N_ROADS - 1; k >= 1; k--) begin
            if (demand[add_mod(cur_q, k)]) begin
                found = 1'b1;
                sel   = add_mod(cur_q, k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= PH_ALLRED;
            cur_q   <= '0;
            nxt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                PH_ALLRED: begin
                    if (expire) begin
                        cnt_q <= '0;
                        if (flash_req) begin
                            state_q <= PH_FLASH;
                        end else begin
                            state_q <= PH_GREEN;
                            cur_q   <= nxt_q;
                        end
                    end else if (half) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                PH_GREEN: begin
                    if (expire) begin
                        cnt_q <= '0;
                        if (found) begin
                            nxt_q   <= sel;
                            state_q <= PH_YELLOW;
                        end else if (!(demand[cur_q] && !flash_req)) begin
                            nxt_q   <= add_mod(cur_q, 1);
                            state_q <= PH_YELLOW;
                        end
                    end else if (half) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                PH_YELLOW: begin
                    if (expire) begin
                        cnt_q   <= '0;
                        state_q <= flash_req ? PH_FLASH : PH_ALLRED;
                    end else if (half) begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                PH_FLASH: begin
                    cnt_q <= '0;
                    if (!flash_req) begin
                        nxt_q   <= add_mod(cur_q, 1);
                        state_q <= PH_ALLRED;
                    end
                end
                default: begin
                    state_q <= PH_ALLRED;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        green  = '0;
        yellow = '0;
        red    = '1;
        case (state_q)
            PH_GREEN: begin
                green[cur_q] = 1'b1;
                red[cur_q]   = 1'b0;
            end
            PH_YELLOW: begin
                yellow[cur_q] = 1'b1;
                red[cur_q]    = 1'b0;
                if (YELLOW_OVERLAP && (nxt_q != cur_q)) begin
                    yellow[nxt_q] = 1'b1;
                    red[nxt_q]    = 1'b0;
                end
            end
            PH_FLASH: begin
                yellow = {N_ROADS{blink}};
                red    = '0;
            end
            default: ;
        endcase
        right_turn = (state_q != PH_FLASH) ? (red & {N_ROADS{blink}}) : '0;
    end

    assign cur_road = cur_q;
    assign phase    = state_q;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - scoreboard bench for traffic_phase_sequencer
module tb_traffic_phase_sequencer;
    import traffic_pkg::*;

    typedef struct {
        logic [1:0] ph;
        logic [1:0] cur;
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        int         len;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rst3;
    logic [3:0] demand;
    logic       flash_req;
    logic [3:0] green, yellow, red, right_turn;
    logic [1:0] cur_road;
    logic [1:0] phase;
    logic [2:0] demand3;
    logic       flash3;
    logic [2:0] green3, yellow3, red3, right_turn3;
    logic [1:0] cur_road3;
    logic [1:0] phase3;

    rec_t sb[$];
    rec_t cur_rec;
    rec_t mrec;
    int   q3[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_en  = 1'b0;
    logic [1:0] last_ph;
    logic [1:0] last_cur;
    logic [2:0] last_g3 = '0;
    int   seg_len = 0;
    int   seg_bad = 0;
    int   inv_bad = 0;
    int   bad3    = 0;

    always #5 clk = ~clk;

    traffic_phase_sequencer #(
        .N_ROADS(4), .CLK_FREQ(4), .GREEN_TIME(2), .YELLOW_TIME(1), .ALLRED_TIME(1), .YELLOW_OVERLAP(1'b1)
    ) u_dut (
        .clk(clk), .rst(rst), .demand(demand), .flash_req(flash_req),
        .green(green), .yellow(yellow), .red(red), .right_turn(right_turn),
        .cur_road(cur_road), .phase(phase)
    );

    traffic_phase_sequencer #(
        .N_ROADS(3), .CLK_FREQ(4), .GREEN_TIME(2), .YELLOW_TIME(1), .ALLRED_TIME(1), .YELLOW_OVERLAP(1'b1)
    ) u_dut3 (
        .clk(clk), .rst(rst3), .demand(demand3), .flash_req(flash3),
        .green(green3), .yellow(yellow3), .red(red3), .right_turn(right_turn3),
        .cur_road(cur_road3), .phase(phase3)
    );

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic void push(input logic [1:0] ph, input logic [1:0] c, input logic [3:0] g,
                                 input logic [3:0] y, input logic [3:0] r, input int len);
        rec_t t;
        t.ph = ph; t.cur = c; t.g = g; t.y = y; t.r = r; t.len = len;
        sb.push_back(t);
    endfunction

    task automatic wait_empty(input int budget, input string nm);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: %0d records still pending after %0d cycles", nm, sb.size(), budget);
            sb.delete();
        end
    endtask

    always @(posedge clk) cyc <= (!rst) ? 0 : cyc + 1;

    // Scoreboard monitor: pops one record on every phase/road change.
    always @(posedge clk) begin
        logic       b;
        logic [3:0] exp_y, exp_rt;
        #1;
        if (!mon_en) begin
            last_ph  = phase;
            last_cur = cur_road;
            seg_len  = 1;
            seg_bad  = 0;
        end else begin
            if (phase !== last_ph || cur_road !== last_cur) begin
                check("seg_steady_lamps", seg_bad, 0);
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_transition: got phase %0d road %0d, expected no change from phase %0d road %0d",
                             phase, cur_road, last_ph, last_cur);
                end else begin
                    mrec = sb.pop_front();
                    check("phase", phase, mrec.ph);
                    check("cur_road", cur_road, mrec.cur);
                    check("green", green, mrec.g);
                    if (mrec.ph != PH_FLASH) check("yellow", yellow, mrec.y);
                    check("red", red, mrec.r);
                    if (mrec.len != 0) check("prev_seg_len", seg_len, mrec.len);
                    cur_rec = mrec;
                end
                last_ph  = phase;
                last_cur = cur_road;
                seg_len  = 1;
                seg_bad  = 0;
            end else begin
                seg_len++;
            end
            b      = cyc[1];
            exp_y  = (cur_rec.ph == PH_FLASH) ? {4{b}} : cur_rec.y;
            exp_rt = (cur_rec.ph == PH_FLASH) ? 4'b0000 : (cur_rec.r & {4{b}});
            if (green !== cur_rec.g || yellow !== exp_y || red !== cur_rec.r || right_turn !== exp_rt)
                seg_bad++;
            if ($countones(green) > 1 || (green & yellow) != 4'b0000) inv_bad++;
            if (phase != PH_FLASH)
                for (int i = 0; i < 4; i++)
                    if ($countones({red[i], yellow[i], green[i]}) != 1) inv_bad++;
        end
    end

    always @(posedge clk) begin
        int e;
        #1;
        if (mon_en) begin
            if (cur_road3 > 2'd2) bad3++;
            if (green3 !== last_g3 && green3 != 3'b000 && q3.size() > 0) begin
                e = q3.pop_front();
                check("n3_green_order", green3, 32'(1) << e);
            end
            last_g3 = green3;
        end
    end

    initial begin
        cur_rec.ph = PH_ALLRED; cur_rec.cur = 2'd0; cur_rec.g = 4'b0000;
        cur_rec.y = 4'b0000; cur_rec.r = 4'b1111; cur_rec.len = 0;
        rst = 1'b0; rst3 = 1'b0; demand = 4'b0000; flash_req = 1'b0;
        demand3 = 3'b000; flash3 = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_phase", phase, PH_ALLRED);
        check("rst_cur_road", cur_road, 0);
        check("rst_red", red, 4'b1111);
        check("rst_green", green, 4'b0000);
        check("rst_yellow", yellow, 4'b0000);
        check("rst_right_turn", right_turn, 4'b0000);
        q3.push_back(0); q3.push_back(1); q3.push_back(2); q3.push_back(0);

        // Full rotation with demand everywhere.
        rst = 1'b1; rst3 = 1'b1; mon_en = 1'b1; demand = 4'b1111;
        push(PH_GREEN,  0, 4'b0001, 4'b0000, 4'b1110, 4);
        push(PH_YELLOW, 0, 4'b0000, 4'b0011, 4'b1100, 8);
        push(PH_ALLRED, 0, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  1, 4'b0010, 4'b0000, 4'b1101, 4);
        push(PH_YELLOW, 1, 4'b0000, 4'b0110, 4'b1001, 8);
        push(PH_ALLRED, 1, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  2, 4'b0100, 4'b0000, 4'b1011, 4);
        push(PH_YELLOW, 2, 4'b0000, 4'b1100, 4'b0011, 8);
        push(PH_ALLRED, 2, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  3, 4'b1000, 4'b0000, 4'b0111, 4);
        push(PH_YELLOW, 3, 4'b0000, 4'b1001, 4'b0110, 8);
        push(PH_ALLRED, 3, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  0, 4'b0001, 4'b0000, 4'b1110, 4);
        wait_empty(200, "rotation");

        // Skip to road 3.
        demand = 4'b1001;
        push(PH_YELLOW, 0, 4'b0000, 4'b1001, 4'b0110, 8);
        push(PH_ALLRED, 0, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  3, 4'b1000, 4'b0000, 4'b0111, 4);
        wait_empty(100, "skip_to_3");

        // Only road 0 wants service: back to 0, then extend.
        demand = 4'b0001;
        push(PH_YELLOW, 3, 4'b0000, 4'b1001, 4'b0110, 8);
        push(PH_ALLRED, 3, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  0, 4'b0001, 4'b0000, 4'b1110, 4);
        wait_empty(100, "back_to_0");
        repeat (44) @(negedge clk);
        demand = 4'b0100;
        push(PH_YELLOW, 0, 4'b0000, 4'b0101, 4'b1010, 48);
        push(PH_ALLRED, 0, 4'b0000, 4'b0000, 4'b1111, 4);
        push(PH_GREEN,  2, 4'b0100, 4'b0000, 4'b1011, 4);
        wait_empty(100, "extension");

        // Flash request mid-green of road 2.
        repeat (3) @(negedge clk);
        flash_req = 1'b1;
        demand = 4'b0000;
        push(PH_YELLOW, 2, 4'b0000, 4'b1100, 4'b0011, 8);
        push(PH_FLASH,  2, 4'b0000, 4'b0000, 4'b0000, 4);
        wait_empty(100, "enter_flash");
        repeat (6) @(negedge clk);
        while (cyc[0] == 1'b0) @(negedge clk);
        flash_req = 1'b0;
        push(PH_ALLRED, 2, 4'b0000, 4'b0000, 4'b1111, 8);
        push(PH_GREEN,  3, 4'b1000, 4'b0000, 4'b0111, 4);
        wait_empty(100, "leave_flash");

        // Reset pulse during yellow.
        push(PH_YELLOW, 3, 4'b0000, 4'b1001, 4'b0110, 8);
        wait_empty(100, "yellow_before_reset");
        @(negedge clk);
        rst = 1'b0;
        push(PH_ALLRED, 0, 4'b0000, 4'b0000, 4'b1111, 2);
        @(negedge clk);
        rst = 1'b1;
        push(PH_GREEN,  0, 4'b0001, 4'b0000, 4'b1110, 4);
        push(PH_YELLOW, 0, 4'b0000, 4'b0011, 4'b1100, 8);
        wait_empty(100, "after_reset");

        check("invariants", inv_bad, 0);
        check("n3_sequence_done", q3.size(), 0);
        check("n3_cur_road_range", bad3, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
- Parametrised N-road intersection controller that cycles green, yellow and all-red clearance across N_ROADS approaches.
- Adds demand-actuated skipping and green extension, a mandatory all-red clearance interval, and a flashing-yellow fallback mode.
- Drives right-turn blink indicators per road.
- Sits between the board clock and reset and the lamp driver pins; it is the drop-in generalisation of the fixed 4-road controller.

Parameters:
- N_ROADS, 4, number of approaches; range 2..16.
- CLK_FREQ, 100_000_000, clock frequency in Hz; must be even and >= 2.
- GREEN_TIME, 30, green duration in seconds; range 1..127.
- YELLOW_TIME, 3, yellow duration in seconds; range 1..127.
- ALLRED_TIME, 1, all-red clearance in seconds; range 1..127.
- YELLOW_OVERLAP, 1, if 1 the next-selected road also shows yellow during YELLOW.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-low reset
- demand  in  N_ROADS  per-road vehicle demand, level-sensitive
- flash_req  in  1  request for flashing-yellow mode
- green  out  N_ROADS  green lamp per road
- yellow  out  N_ROADS  yellow lamp per road
- red  out  N_ROADS  red lamp per road
- right_turn  out  N_ROADS  right-turn blink indicator per road
- cur_road  out  RW = max(1, clog2(N_ROADS))  road currently owning the phase
- phase  out  2  00=ALLRED, 01=GREEN, 10=YELLOW, 11=FLASH

Behaviour:
- Reset:
  - Reset is synchronous on rst==0 at a clk edge.
  - State=ALLRED, cur_road=0, nxt_road=0, all counters 0, blink=0.
  - Outputs during and after reset: red=all 1, green=0, yellow=0, right_turn=0.
  - Reset asserted mid-phase aborts the phase on the next edge.
- Timebase:
  - tick_gen emits a 1-cycle pulse `half` every CLK_FREQ/2 cycles.
  - `blink` toggles on each `half` pulse.
  - The phase counter (8 bits) counts `half` pulses only.
  - A phase of T seconds expires on the clock where `half`=1 and count==2*T-1; the counter clears to 0 on every state change.
- States and transitions (all registered, one clock per transition):
  - ALLRED: on expiry go to GREEN with cur_road<=nxt_road. If flash_req=1 at expiry, go to FLASH instead.
  - GREEN, at expiry, evaluate sel = first road with demand searching cur+1, cur+2, ... cur+N-1 (mod N):
    - sel found: nxt_road<=sel, go to YELLOW.
    - No other demand but demand[cur]=1: stay in GREEN, counter restarts (extension; no yellow).
    - demand all 0: nxt_road<=(cur+1) mod N, go to YELLOW.
    - If flash_req=1 at expiry, always go to YELLOW; nxt_road is chosen by the rules above.
  - YELLOW: on expiry go to ALLRED. If flash_req=1 at expiry, go to FLASH instead.
  - FLASH: stays while flash_req=1. On the first clock with flash_req=0, set nxt_road<=(cur+1) mod N and go to ALLRED with a fresh counter.
  - flash_req never interrupts GREEN or YELLOW early.
- Output decode (combinational from registered state; zero latency):
  - GREEN: green[cur]=1, red[cur]=0; all other roads red.
  - YELLOW: yellow[cur]=1, red[cur]=0. If YELLOW_OVERLAP=1 and nxt!=cur, also yellow[nxt]=1, red[nxt]=0.
  - ALLRED: all red.
  - FLASH: yellow=all blink, red=0, green=0.
  - right_turn[i]=blink when red[i]=1 and phase!=FLASH; otherwise 0.
- Invariants:
  - At most one green bit set at any time.
  - green and yellow are never both set on the same road.
  - Every road's lamps are one-hot (red/yellow/green) outside FLASH.
- cur_road and nxt_road are always < N_ROADS; wrap-around is by compare-and-reset, not by power-of-2 truncation.

Decomposition:
- traffic_pkg:
  - phase enum (ALLRED, GREEN, YELLOW, FLASH) with the encoding above.
  - road-index width function.
  - Constant HALF_CYCLES = CLK_FREQ/2.
- Sub-module tick_gen (parameter CLK_FREQ; ports clk, rst, half, blink): 32-bit prescaler plus blink toggle.
- Main module: FSM, phase counter, priority search and output decode.

Test Plan:
(Unless stated, benches use CLK_FREQ=4, GREEN_TIME=2, YELLOW_TIME=1, ALLRED_TIME=1, N_ROADS=4; `half` every 2 cycles, so green=8, yellow=4, allred=4 cycles.)
- Reset then demand=4'b1111 -> ALLRED 4 cycles, GREEN road0 8 cycles, YELLOW 4 cycles (yellow=0011), ALLRED 4 cycles, GREEN road1; order 0,1,2,3,0 repeats.
- demand=4'b1001, cur=0 at green expiry -> nxt=3, yellow=1001 during YELLOW, next green on road3; road1 and road2 never green.
- demand=4'b0001 held -> road0 stays GREEN indefinitely; counter restarts every 8 cycles; yellow stays 0.
- flash_req raised mid-GREEN of road2 -> green holds to expiry, then YELLOW 4 cycles, then FLASH: yellow=1111 toggling every 2 cycles, red=0, right_turn=0. Drop flash_req -> ALLRED 4 cycles, then GREEN road3.
- rst low for 1 cycle during YELLOW -> next cycle: phase=ALLRED, cur_road=0, red=1111, counters 0.
- N_ROADS=3, demand=0 -> green order 0,1,2,0; cur_road never reads 3. Assertions: single-green and per-road one-hot invariants hold throughout all tests.
